// File: rtl/pll_drp_sequencer_if.sv
// Signal bundle between the host, the DRP sequencer and the PLL DRP/RST pins.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface pll_drp_sequencer_if #(
  parameter int DEPTH = 8
);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic            CFG_WE;
  logic [IDXW-1:0] CFG_IDX;
  logic [6:0]      CFG_ADDR;
  logic [15:0]     CFG_MASK;
  logic [15:0]     CFG_DATA;
  logic            SEN;
  logic [CNTW-1:0] SCOUNT;
  logic            BUSY;
  logic            SRDY;
  logic            ERR;
  logic [6:0]      DADDR;
  logic            DEN;
  logic            DWE;
  logic [15:0]     DI;
  logic [15:0]     DO;
  logic            DRDY;
  logic            LOCKED;
  logic            PLL_RST;
  logic [3:0]      DBG_STATE;

  modport slave (
    input  CFG_WE, CFG_IDX, CFG_ADDR, CFG_MASK, CFG_DATA, SEN, SCOUNT, DO, DRDY, LOCKED,
    output BUSY, SRDY, ERR, DADDR, DEN, DWE, DI, PLL_RST, DBG_STATE
  );

  modport master (
    output CFG_WE, CFG_IDX, CFG_ADDR, CFG_MASK, CFG_DATA, SEN, SCOUNT, DO, DRDY, LOCKED,
    input  BUSY, SRDY, ERR, DADDR, DEN, DWE, DI, PLL_RST, DBG_STATE
  );
endinterface

// File: rtl/pll_drp_sequencer.sv
// PLL DRP reconfiguration sequencer: holds the PLL in reset, read-modify-writes
// a host-loaded table of DRP registers, releases reset and waits for lock.
module pll_drp_sequencer #(
  parameter int DEPTH        = 8,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 4096
) (
  input logic                 DCLK,
  input logic                 RST,
  pll_drp_sequencer_if.slave  bus
);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int TMAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ARST      = 4'd1,
    S_READ      = 4'd2,
    S_WAIT_R    = 4'd3,
    S_WRITE     = 4'd4,
    S_WAIT_W    = 4'd5,
    S_RELEASE   = 4'd6,
    S_WAIT_LOCK = 4'd7,
    S_DONE      = 4'd8,
    S_ABORT     = 4'd9
  } state_t;

  // Handshakes: SEN is a request accepted only in a cycle with BUSY=0, and every
  // accepted request is answered by exactly one SRDY pulse. DEN is a one-cycle
  // request and the access stays outstanding until DRDY is sampled in a wait state.

  logic [6:0]  tbl_addr_q [DEPTH];
  logic [15:0] tbl_mask_q [DEPTH];
  logic [15:0] tbl_data_q [DEPTH];

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] n_q, n_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [6:0]      daddr_q, daddr_d;
  logic [15:0]     di_q, di_d;

  logic            idle;
  logic            cfg_wr;
  logic [CNTW-1:0] scount_sat;
  logic [CNTW-1:0] ptr_next;
  logic            last;
  logic [TW-1:0]   timer_inc;
  logic [6:0]      cur_addr;
  logic [15:0]     cur_mask;
  logic [15:0]     cur_data;
  logic [15:0]     wr_val;

  assign idle       = (state_q == S_IDLE);
  assign cfg_wr     = idle && bus.CFG_WE && ({1'b0, bus.CFG_IDX} < (IDXW + 1)'(DEPTH));
  assign scount_sat = (bus.SCOUNT > CNTW'(DEPTH)) ? CNTW'(DEPTH) : bus.SCOUNT;
  assign ptr_next   = CNTW'(ptr_q) + CNTW'(1);
  assign last       = (ptr_next >= n_q);
  assign timer_inc  = timer_q + TW'(1);
  assign cur_addr   = tbl_addr_q[ptr_q];
  assign cur_mask   = tbl_mask_q[ptr_q];
  assign cur_data   = tbl_data_q[ptr_q];
  // Mask bits keep the PLL's current contents; the rest come from the table.
  assign wr_val     = (rdata_q & cur_mask) | (cur_data & ~cur_mask);

  // The table survives RST so a host can re-run the last configuration.
  always_ff @(posedge DCLK) begin
    if (cfg_wr) begin
      tbl_addr_q[bus.CFG_IDX] <= bus.CFG_ADDR;
      tbl_mask_q[bus.CFG_IDX] <= bus.CFG_MASK;
      tbl_data_q[bus.CFG_IDX] <= bus.CFG_DATA;
    end
  end

  always_ff @(posedge DCLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      n_q     <= '0;
      timer_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      daddr_q <= '0;
      di_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      n_q     <= n_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      daddr_q <= daddr_d;
      di_q    <= di_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    n_d     = n_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    daddr_d = daddr_q;
    di_d    = di_q;
    case (state_q)
      S_IDLE: begin
        if (bus.SEN) begin
          state_d = S_ARST;
          n_d     = scount_sat;
          ptr_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_ARST: state_d = (n_q == '0) ? S_RELEASE : S_READ;
      S_READ: begin
        state_d = S_WAIT_R;
        timer_d = '0;
        daddr_d = cur_addr;
      end
      S_WAIT_R: begin
        timer_d = timer_inc;
        if (bus.DRDY) begin
          rdata_d = bus.DO;
          state_d = S_WRITE;
        end else if (timer_inc == TW'(DRDY_TIMEOUT)) begin
          state_d = S_ABORT;
        end
      end
      S_WRITE: begin
        state_d = S_WAIT_W;
        timer_d = '0;
        daddr_d = cur_addr;
        di_d    = wr_val;
      end
      S_WAIT_W: begin
        timer_d = timer_inc;
        if (bus.DRDY) begin
          if (last) begin
            state_d = S_RELEASE;
          end else begin
            state_d = S_READ;
            ptr_d   = IDXW'(ptr_next);
          end
        end else if (timer_inc == TW'(DRDY_TIMEOUT)) begin
          state_d = S_ABORT;
        end
      end
      S_RELEASE: begin
        state_d = S_WAIT_LOCK;
        timer_d = '0;
      end
      S_WAIT_LOCK: begin
        timer_d = timer_inc;
        if (bus.LOCKED) begin
          state_d = S_DONE;
        end else if (timer_inc == TW'(LOCK_TIMEOUT)) begin
          state_d = S_ABORT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ABORT) err_d = 1'b1;
  end

  always_comb begin
    bus.BUSY      = (state_q != S_IDLE);
    bus.SRDY      = (state_q == S_DONE) || (state_q == S_ABORT);
    bus.ERR       = err_q;
    bus.DEN       = (state_q == S_READ) || (state_q == S_WRITE);
    bus.DWE       = (state_q == S_WRITE);
    bus.DADDR     = bus.DEN ? cur_addr : daddr_q;
    bus.DI        = (state_q == S_WRITE) ? wr_val : di_q;
    bus.PLL_RST   = (state_q == S_ARST) || (state_q == S_READ) || (state_q == S_WAIT_R) ||
                    (state_q == S_WRITE) || (state_q == S_WAIT_W);
    bus.DBG_STATE = state_q;
  end
endmodule

// File: tb/tb_pll_drp_sequencer.sv
// Directed bench for pll_drp_sequencer: DRP and PLL lock models, a scoreboard of
// expected DRP accesses and sequence endings, and a monitor that checks them.
module tb_pll_drp_sequencer;
  localparam int DEPTH   = 8;
  localparam int DRDY_TO = 16;
  localparam int LOCK_TO = 40;
  localparam int IDXW    = 3;
  localparam int CNTW    = 4;
  localparam int DW      = 25;
  localparam int EW      = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pll_drp_sequencer_if #(.DEPTH(DEPTH)) bus ();

  pll_drp_sequencer #(
    .DEPTH(DEPTH), .DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO)
  ) dut (
    .DCLK(clk), .RST(rst), .bus(bus)
  );

  // {pll_rst, dwe, daddr, di (writes only)}
  logic [DW-1:0] exp_q[$];
  // {err, pll_rst, cycles from accepted SEN to SRDY}
  logic [EW-1:0] exp_end_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  bit outstanding = 1'b0;

  logic [15:0] drp_mem [128];
  int drp_lat = 1;
  int drop_rd = -1;
  int rd_cnt = 0;
  int lock_delay = 1;
  bit lock_never = 1'b0;
  int low_cnt = 0;

  logic [6:0]  t_a [DEPTH];
  logic [15:0] t_m [DEPTH];
  logic [15:0] t_d [DEPTH];

  logic [DW-1:0] mon_e;
  logic [EW-1:0] mon_end;
  logic [6:0]    dm_a;
  bit            dm_w;
  bit            dm_skip;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic void exp_acc(bit wr, logic [6:0] a, logic [15:0] di);
    exp_q.push_back({1'b1, wr, a, wr ? di : 16'h0000});
  endfunction

  function automatic void exp_entry(int i);
    exp_acc(1'b0, t_a[i], 16'h0000);
    exp_acc(1'b1, t_a[i], (drp_mem[t_a[i]] & t_m[i]) | (t_d[i] & ~t_m[i]));
  endfunction

  function automatic void exp_seq_end(bit err, int off);
    exp_end_q.push_back({err, 1'b0, 16'(off)});
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      outstanding = 1'b0;
    end else begin
      if (bus.SEN && !bus.BUSY) start_cyc = cyc;
      if (bus.DEN) begin
        check("den_overlap", 32'(outstanding), 32'd0);
        outstanding = 1'b1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_den: got access dwe=%0b addr=%0h, expected none", bus.DWE, bus.DADDR);
        end else begin
          mon_e = exp_q.pop_front();
          check("drp_access", 32'({bus.PLL_RST, bus.DWE, bus.DADDR, bus.DWE ? bus.DI : 16'h0000}),
                32'(mon_e));
        end
      end
      if (bus.DRDY) outstanding = 1'b0;
      if (bus.SRDY) begin
        outstanding = 1'b0;
        if (exp_end_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_srdy: got SRDY err=%0b, expected none", bus.ERR);
        end else begin
          mon_end = exp_end_q.pop_front();
          check("seq_end", 32'({bus.ERR, bus.PLL_RST, 16'(cyc - start_cyc)}), 32'(mon_end));
        end
      end
    end
  end

  // DRP slave model: answers each DEN after drp_lat cycles unless told to drop a read
  initial begin
    bus.DRDY = 1'b0;
    bus.DO   = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst && bus.DEN) begin
        dm_a    = bus.DADDR;
        dm_w    = bus.DWE;
        dm_skip = 1'b0;
        if (!dm_w) begin
          dm_skip = (rd_cnt == drop_rd);
          rd_cnt++;
        end
        if (!dm_skip) begin
          repeat (drp_lat) @(posedge clk);
          #1;
          bus.DRDY = 1'b1;
          bus.DO   = dm_w ? 16'h0000 : drp_mem[dm_a];
          @(posedge clk);
          #1;
          bus.DRDY = 1'b0;
        end
      end
    end
  end

  // PLL lock model: LOCKED rises lock_delay cycles after PLL_RST falls
  initial begin
    bus.LOCKED = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.PLL_RST || lock_never) begin
        bus.LOCKED = 1'b0;
        low_cnt = 0;
      end else begin
        if (low_cnt >= lock_delay) bus.LOCKED = 1'b1;
        low_cnt++;
      end
    end
  end

  task automatic cfg_write(int idx, logic [6:0] a, logic [15:0] m, logic [15:0] d);
    @(posedge clk);
    #1;
    bus.CFG_WE = 1'b1;
    bus.CFG_IDX = IDXW'(idx);
    bus.CFG_ADDR = a;
    bus.CFG_MASK = m;
    bus.CFG_DATA = d;
    @(posedge clk);
    #1;
    bus.CFG_WE = 1'b0;
  endtask

  task automatic start(int cnt);
    @(posedge clk);
    #1;
    bus.SEN = 1'b1;
    bus.SCOUNT = CNTW'(cnt);
    @(posedge clk);
    #1;
    bus.SEN = 1'b0;
  endtask

  task automatic wait_end(int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.SRDY && k < budget);
    if (!bus.SRDY) begin
      n_cmp++;
      n_fail++;
      $display("FAIL seq_timeout: no SRDY within %0d cycles", budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.CFG_WE = 1'b0;
    bus.CFG_IDX = '0;
    bus.CFG_ADDR = '0;
    bus.CFG_MASK = '0;
    bus.CFG_DATA = '0;
    bus.SEN = 1'b0;
    bus.SCOUNT = '0;
    for (int a = 0; a < 128; a++) drp_mem[a] = 16'h0F0F ^ (16'(a) * 16'h0101);
    for (int i = 0; i < DEPTH; i++) begin
      t_a[i] = 7'h20 + 7'(i);
      t_m[i] = 16'hFF00 >> i;
      t_d[i] = 16'h5A5A ^ 16'(i * 16'h0111);
    end

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_srdy", 32'(bus.SRDY), 32'd0);
    check("rst_err", 32'(bus.ERR), 32'd0);
    check("rst_den", 32'(bus.DEN), 32'd0);
    check("rst_dwe", 32'(bus.DWE), 32'd0);
    check("rst_daddr", 32'(bus.DADDR), 32'd0);
    check("rst_di", 32'(bus.DI), 32'd0);
    check("rst_pll_rst", 32'(bus.PLL_RST), 32'd0);

    // Single entry, 3-cycle DRP latency, lock 10 cycles after release
    drp_mem[8] = 16'hA5A5;
    drp_lat = 3;
    lock_delay = 10;
    cfg_write(0, 7'h08, 16'hF000, 16'h0041);
    exp_acc(1'b0, 7'h08, 16'h0000);
    exp_acc(1'b1, 7'h08, 16'hA041);
    exp_seq_end(1'b0, 21);
    start(1);
    check("arst_busy", 32'(bus.BUSY), 32'd1);
    check("arst_pll_rst", 32'(bus.PLL_RST), 32'd1);
    wait_end(100);
    repeat (2) @(posedge clk);
    #1;
    check("daddr_hold", 32'(bus.DADDR), 32'h08);
    check("di_hold", 32'(bus.DI), 32'hA041);

    // SEN and CFG_WE together while idle: sequence uses the new entry
    drp_lat = 1;
    lock_delay = 1;
    drp_mem[5] = 16'h1234;
    exp_acc(1'b0, 7'h05, 16'h0000);
    exp_acc(1'b1, 7'h05, 16'hBE34);
    exp_seq_end(1'b0, 8);
    @(posedge clk);
    #1;
    bus.CFG_WE = 1'b1;
    bus.CFG_IDX = '0;
    bus.CFG_ADDR = 7'h05;
    bus.CFG_MASK = 16'h00FF;
    bus.CFG_DATA = 16'hBE00;
    bus.SEN = 1'b1;
    bus.SCOUNT = CNTW'(1);
    @(posedge clk);
    #1;
    bus.CFG_WE = 1'b0;
    bus.SEN = 1'b0;
    wait_end(50);

    // Full table, immediate DRDY/LOCKED, then SCOUNT above DEPTH clamps to DEPTH
    for (int i = 0; i < DEPTH; i++) cfg_write(i, t_a[i], t_m[i], t_d[i]);
    for (int i = 0; i < DEPTH; i++) exp_entry(i);
    exp_seq_end(1'b0, 36);
    start(8);
    wait_end(100);
    for (int i = 0; i < DEPTH; i++) exp_entry(i);
    exp_seq_end(1'b0, 36);
    start(12);
    wait_end(100);

    // Second read never answered -> DRDY timeout abort
    rd_cnt = 0;
    drop_rd = 1;
    exp_entry(0);
    exp_acc(1'b0, t_a[1], 16'h0000);
    exp_seq_end(1'b1, 23);
    start(2);
    wait_end(100);
    drop_rd = -1;
    repeat (3) @(posedge clk);
    #1;
    check("err_held_idle", 32'(bus.ERR), 32'd1);
    check("busy_after_abort", 32'(bus.BUSY), 32'd0);
    exp_entry(0);
    exp_seq_end(1'b0, 8);
    start(1);
    check("err_cleared_on_sen", 32'(bus.ERR), 32'd0);
    wait_end(50);

    // SCOUNT=0 with LOCKED stuck low -> lock timeout, no DRP traffic
    lock_never = 1'b1;
    exp_seq_end(1'b1, 3 + LOCK_TO);
    start(0);
    check("n0_pll_rst", 32'(bus.PLL_RST), 32'd1);
    wait_end(100);
    lock_never = 1'b0;

    // SEN/CFG_WE while busy (mid-run and in the SRDY cycle) are ignored
    exp_entry(0);
    exp_entry(1);
    exp_seq_end(1'b0, 12);
    start(2);
    bus.SEN = 1'b1;
    bus.SCOUNT = CNTW'(1);
    bus.CFG_WE = 1'b1;
    bus.CFG_IDX = IDXW'(0);
    bus.CFG_ADDR = 7'h7F;
    bus.CFG_MASK = 16'h0000;
    bus.CFG_DATA = 16'hFFFF;
    @(posedge clk);
    #1;
    bus.SEN = 1'b0;
    bus.CFG_WE = 1'b0;
    wait_end(50);
    bus.SEN = 1'b1;
    bus.CFG_WE = 1'b1;
    bus.CFG_IDX = IDXW'(1);
    @(posedge clk);
    #1;
    bus.SEN = 1'b0;
    bus.CFG_WE = 1'b0;
    check("busy_after_ignored_sen", 32'(bus.BUSY), 32'd0);
    exp_entry(0);
    exp_entry(1);
    exp_seq_end(1'b0, 12);
    start(2);
    wait_end(50);

    // RST during WAIT_W, late DRDY afterwards, table preserved
    drp_lat = 3;
    exp_entry(0);
    start(2);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.DEN && bus.DWE) && k < 50);
    if (!(bus.DEN && bus.DWE)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_write_den: no write DEN within 50 cycles");
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_busy", 32'(bus.BUSY), 32'd0);
    check("rst_mid_pll_rst", 32'(bus.PLL_RST), 32'd0);
    check("rst_mid_den", 32'(bus.DEN), 32'd0);
    check("rst_mid_srdy", 32'(bus.SRDY), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("late_drdy_busy", 32'(bus.BUSY), 32'd0);
    drp_lat = 1;
    exp_entry(0);
    exp_entry(1);
    exp_seq_end(1'b0, 12);
    start(2);
    wait_end(50);

    repeat (4) @(posedge clk);
    #1;
    check("drp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("end_queue_drained", 32'(exp_end_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pll_drp_sequencer.md
# pll_drp_sequencer

Reconfiguration sequencer for the PLL's dynamic reconfiguration port (DRP). It holds a small host-loaded table of (address, mask, data) entries. On a start strobe it holds the PLL in reset, performs a read-modify-write of each table entry over the DRP, releases reset and waits for LOCKED. It sits between a host/control FSM and the PLL instance, driving the DADDR/DEN/DWE/DI/DO/DRDY port and RST that `PLLE2_BASE` currently ties off.

## Interface
Parameters:
- DEPTH, 8, number of table entries (1..32)
- DRDY_TIMEOUT, 64, max DCLK cycles to wait for DRDY after a DEN pulse
- LOCK_TIMEOUT, 4096, max DCLK cycles to wait for LOCKED after reset release

Ports:
- DCLK  in  1  sole clock; DRP clock of the PLL
- RST  in  1  synchronous, active-high reset
- CFG_WE  in  1  table write strobe; ignored while BUSY=1
- CFG_IDX  in  clog2(DEPTH)  table entry index
- CFG_ADDR  in  7  DRP register address for the entry
- CFG_MASK  in  16  bits to keep from the read value (1 = keep)
- CFG_DATA  in  16  bits to insert where MASK=0
- SEN  in  1  start strobe; ignored while BUSY=1
- SCOUNT  in  clog2(DEPTH+1)  entries to apply, 0..DEPTH; sampled with SEN
- BUSY  out  1  sequence in progress
- SRDY  out  1  one-cycle pulse when a sequence ends (success or error)
- ERR  out  1  last sequence aborted by timeout; cleared on next accepted SEN
- DADDR  out  7  DRP address to PLL
- DEN  out  1  DRP enable, one-cycle pulse
- DWE  out  1  DRP write enable, valid with DEN
- DI  out  16  DRP write data
- DO  in  16  DRP read data, valid with DRDY
- DRDY  in  1  DRP access complete
- LOCKED  in  1  PLL lock indicator
- PLL_RST  out  1  reset to PLL RST pin

## Operation
- Table: DEPTH entries of {addr[6:0], mask[15:0], data[15:0]}.
  - A CFG_WE=1 cycle with BUSY=0 writes entry CFG_IDX; the entry is usable on the next cycle.
  - RST does not clear the table.
- Write value per entry: (DO & mask) | (data & ~mask).
- SEN=1 with BUSY=0 accepts a sequence:
  - latches n = min(SCOUNT, DEPTH);
  - clears ERR;
  - sets entry pointer i=0.
- States:
  - IDLE: wait for accepted SEN, then go to ARST.
  - ARST: PLL_RST=1. If n=0 go to RELEASE, else go to READ.
  - READ: DEN=1, DWE=0, DADDR=addr[i]; clear timer. Next state WAIT_R.
  - WAIT_R: on DRDY, capture DO and go to WRITE. If the timer reaches DRDY_TIMEOUT, go to ABORT.
  - WRITE: DEN=1, DWE=1, DADDR=addr[i], DI=computed value; clear timer. Next state WAIT_W.
  - WAIT_W: on DRDY, go to READ with i+1 if i+1<n, else go to RELEASE. Timeout goes to ABORT.
  - RELEASE: PLL_RST=0; clear timer. Next state WAIT_LOCK.
  - WAIT_LOCK: LOCKED=1 goes to DONE. Reaching LOCK_TIMEOUT goes to ABORT.
  - DONE: SRDY=1 for one cycle, then IDLE.
  - ABORT: PLL_RST=0, ERR=1, SRDY=1 for one cycle, then IDLE.
- PLL_RST is 1 from ARST through the last WAIT_W, and 0 in every other state.
- BUSY=1 in every state except IDLE.
- DRDY arriving in any state other than WAIT_R/WAIT_W is ignored.
- DEN is never asserted while a prior access is outstanding.
- DADDR and DI hold their last driven value when DEN=0.

## Timing
- Reset values: BUSY 0, SRDY 0, ERR 0, DEN 0, DWE 0, DADDR 0, DI 0, PLL_RST 0; state IDLE.
- RST mid-sequence:
  - next cycle is IDLE with all outputs at reset values;
  - PLL_RST drops immediately;
  - an outstanding DRP access is abandoned.
- Sequence timing:
  - SEN accepted at cycle t: BUSY=1 and PLL_RST=1 at t+1 (ARST).
  - First DEN read pulse at t+2.
  - A DRDY sampled in cycle c gives the write DEN at c+1.
  - A DRDY with zero DRP latency (DRDY one cycle after DEN) costs 2 cycles per access.
  - Sequence length with immediate DRDY and LOCKED: 2 + 4n + 2 cycles to SRDY.
- SEN and CFG_WE are both ignored while BUSY=1, including during the SRDY cycle.
- SEN and CFG_WE in the same cycle while IDLE: both take effect. The sequence sees the new entry, because READ occurs at least one cycle later.
- Timers:
  - width clog2(max(DRDY_TIMEOUT, LOCK_TIMEOUT)+1);
  - count from 0 on entering the wait state;
  - timeout fires when the count equals the parameter.

## Test plan
- Single entry: load entry 0 = {0x08, 0xF000, 0x0041}, SCOUNT=1, DRP model returns DO=0xA5A5 with 3-cycle latency, LOCKED rises 10 cycles after PLL_RST falls -> read at 0x08, write DI=0xA041 to 0x08, PLL_RST high throughout both accesses, SRDY one cycle, ERR=0.
- Full table: DEPTH=8, SCOUNT=8, immediate DRDY and LOCKED -> 8 read/write pairs at ascending table addresses, SRDY exactly 2+32+2 cycles after the SEN cycle.
- DRDY timeout: DRP model never answers the second read -> ABORT after DRDY_TIMEOUT cycles, PLL_RST=0, ERR=1, SRDY pulse. A following good SEN clears ERR.
- Lock timeout: LOCKED held 0 -> SRDY and ERR=1 exactly LOCK_TIMEOUT cycles after RELEASE. SCOUNT=0 case: no DEN pulses, only the reset pulse and lock wait.
- Ignored inputs: SEN and CFG_WE pulsed while BUSY -> no restart, table unchanged. Verify this by reading the sequence back on the next run.
- RST asserted during WAIT_W -> next cycle IDLE, PLL_RST=0, DEN=0, BUSY=0. A late DRDY is ignored, and the table is preserved for the next SEN.
